// File: rtl/cv32e40x_pkg.sv
// Shared ALU type definitions for the cv32e40x execute stage.
package cv32e40x_pkg;

  // Top-level ALU operation encoding as decoded by the instruction decoder.
  typedef enum logic [5:0] {
    ALU_ADD    = 6'h18,
    ALU_SUB    = 6'h19,
    ALU_XOR    = 6'h2F,
    ALU_OR     = 6'h2E,
    ALU_AND    = 6'h15,
    ALU_CLMUL  = 6'h10,
    ALU_CLMULH = 6'h11,
    ALU_CLMULR = 6'h12
  } alu_opcode_e;

  // Result selection for the carry-less multiplier.
  typedef enum logic [1:0] {
    CLMUL  = 2'b00,  // low half of the product
    CLMULH = 2'b01,  // high half of the product
    CLMULR = 2'b10   // product bits [2W-2:W-1]
  } clmul_op_e;

endpackage

// File: rtl/cv32e40x_alu_clmul_step.sv
// One iteration of the carry-less multiplier: folds a BITS_PER_CYCLE-bit
// multiplier slice into the accumulator using XOR in place of addition.
module cv32e40x_alu_clmul_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc_i,
  input  logic [2*WIDTH-1:0]        a_i,
  input  logic [BITS_PER_CYCLE-1:0] slice_i,
  output logic [2*WIDTH-1:0]        acc_o
);

  // XOR each shifted partial product selected by the slice into the accumulator.
  always_comb begin
    // NOTE: the output gets a default before the loop so no path leaves it
    // unassigned (no latch); blocking assignments let each iteration build on
    // the previous one.
    acc_o = acc_i;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (slice_i[i]) acc_o = acc_o ^ (a_i << i);
    end
  end

endmodule

// File: rtl/cv32e40x_alu_clmul.sv
// Iterative carry-less multiplier (CLMUL/CLMULH/CLMULR) with a valid/ready
// request side and a valid/ready result side. Consumes BITS_PER_CYCLE
// multiplier bits per cycle, so one operation takes WIDTH/BITS_PER_CYCLE cycles.
module cv32e40x_alu_clmul
  import cv32e40x_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  clmul_op_e        operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  // A slice width that is not a power of two or does not tile the operand
  // would leave multiplier bits unconsumed.
  if ((BITS_PER_CYCLE == 0) || ((BITS_PER_CYCLE & (BITS_PER_CYCLE - 1)) != 0) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_bits_per_cycle
    $error("cv32e40x_alu_clmul: BITS_PER_CYCLE must be a power of two dividing WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d;      // multiplicand, pre-shifted to the current slice
  logic [WIDTH-1:0]   b_q, b_d;      // multiplier, consumed from the LSB end
  clmul_op_e          op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   result_sel;

  cv32e40x_alu_clmul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .slice_i (b_q[BITS_PER_CYCLE-1:0]),
    .acc_o   (acc_step)
  );

  // Next-state and datapath update; kill overrides accept, step and ready.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !kill_i) begin
          a_d     = {{WIDTH{1'b0}}, operand_a_i};
          b_d     = operand_b_i;
          op_d    = operator_i;
          acc_d   = '0;
          cnt_d   = CNT_W'(N);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        a_d   = a_q << BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand, accumulator and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments; these datapath
    // registers are reset so a discarded operation leaves nothing behind.
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= CLMUL;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Select the requested product window; zero whenever no result is offered.
  always_comb begin
    result_sel = '0;
    case (op_q)
      CLMUL:   result_sel = acc_q[WIDTH-1:0];
      CLMULH:  result_sel = acc_q[2*WIDTH-1:WIDTH];
      CLMULR:  result_sel = acc_q[2*WIDTH-2:WIDTH-1];
      default: result_sel = '0;
    endcase
    result_o = (state_q == DONE) ? result_sel : '0;
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);

endmodule

// File: tb/tb_cv32e40x_alu_clmul.sv
// Directed bench for the iterative carry-less multiplier: a 1-bit/cycle
// instance and a 4-bit/cycle instance, with a result scoreboard.
module tb_cv32e40x_alu_clmul;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_i, kill_i;
  logic        valid4_i, ready4_i;
  clmul_op_e   operator_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        ready_o, valid_o, ready4_o, valid4_o;
  logic [31:0] result_o, result4_o;

  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cv32e40x_alu_clmul #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );

  cv32e40x_alu_clmul #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid4_i), .ready_o(ready4_o),
    .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .kill_i(kill_i), .valid_o(valid4_o), .ready_i(ready4_i), .result_o(result4_o)
  );

  function automatic logic [31:0] clmul_ref(input clmul_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
    case (op)
      CLMUL:   return p[31:0];
      CLMULH:  return p[63:32];
      default: return p[62:31];
    endcase
  endfunction

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, let it be accepted, then scramble the inputs.
  task automatic issue(input bit sel, input clmul_op_e op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    operator_i = op; operand_a_i = a; operand_b_i = b;
    if (sel) valid4_i = 1'b1; else valid_i = 1'b1;
    check(32'(sel ? ready4_o : ready_o), 32'd1, "ready_before_accept");
    @(posedge clk); #1;
    valid_i = 1'b0; valid4_i = 1'b0;
    operand_a_i = $urandom; operand_b_i = $urandom; operator_i = CLMULR;
    sb.push_back(clmul_ref(op, a, b));
  endtask

  // Called #1 after the accept edge; counts edges until valid_o rises.
  task automatic wait_result(input bit sel, input int exp_lat, input string tag);
    int          lat;
    logic [31:0] exp;
    lat = 0;
    while (((sel ? valid4_o : valid_o) !== 1'b1) && (lat < 100)) begin
      @(posedge clk); #1;
      lat++;
    end
    check(32'(lat), 32'(exp_lat), {tag, "_latency"});
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    check(sel ? result4_o : result_o, exp, {tag, "_result"});
  endtask

  task automatic consume(input bit sel, input string tag);
    if (sel) ready4_i = 1'b1; else ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0; ready4_i = 1'b0;
    check(32'(sel ? valid4_o : valid_o), 32'd0, {tag, "_valid_drop"});
    check(32'(sel ? ready4_o : ready_o), 32'd1, {tag, "_ready_back"});
  endtask

  initial begin
    logic [31:0] held, a, b;
    clmul_op_e   op;
    int          seen;

    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; kill_i = 1'b0;
    valid4_i = 1'b0; ready4_i = 1'b0;
    operator_i = CLMUL; operand_a_i = '0; operand_b_i = '0;
    #1;
    check(32'(ready_o), 32'd1, "reset_ready");
    check(32'(valid_o), 32'd0, "reset_valid");
    check(result_o, 32'd0, "reset_result");
    #11 rst_n = 1'b1;

    // Basic product and exact latency.
    issue(0, CLMUL, 32'h3, 32'h3);
    wait_result(0, 32, "clmul_3x3");
    consume(0, "clmul_3x3");

    // Product straddling the halves selects differently per operator.
    issue(0, CLMUL, 32'h80000000, 32'h2);  wait_result(0, 32, "msb_clmul");  consume(0, "msb_clmul");
    issue(0, CLMULH, 32'h80000000, 32'h2); wait_result(0, 32, "msb_clmulh"); consume(0, "msb_clmulh");
    issue(0, CLMULR, 32'h80000000, 32'h2); wait_result(0, 32, "msb_clmulr"); consume(0, "msb_clmulr");
    check(clmul_ref(CLMULR, 32'h80000000, 32'h2), 32'h2, "model_clmulr_sanity");

    // All-ones operands.
    issue(0, CLMUL, 32'hFFFFFFFF, 32'hFFFFFFFF);  wait_result(0, 32, "ones_clmul");  consume(0, "ones_clmul");
    issue(0, CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_result(0, 32, "ones_clmulh"); consume(0, "ones_clmulh");
    issue(0, CLMULR, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_result(0, 32, "ones_clmulr"); consume(0, "ones_clmulr");

    // Random operands against the reference model.
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom; op = clmul_op_e'($urandom_range(0, 2));
      issue(0, op, a, b);
      wait_result(0, 32, "random");
      consume(0, "random");
    end

    // Backpressure: result held for 5 cycles, no accept on the DONE->IDLE edge.
    issue(0, CLMULH, 32'h12345678, 32'h9ABCDEF0);
    held = clmul_ref(CLMULH, 32'h12345678, 32'h9ABCDEF0);
    wait_result(0, 32, "bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check(32'(valid_o), 32'd1, "bp_valid_held");
      check(result_o, held, "bp_result_stable");
    end
    @(negedge clk);
    ready_i = 1'b1; valid_i = 1'b1;
    operator_i = CLMUL; operand_a_i = 32'h3; operand_b_i = 32'h3;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check(32'(valid_o), 32'd0, "bp_release_valid");
    check(32'(ready_o), 32'd1, "bp_no_accept_in_done");
    @(posedge clk); #1;
    valid_i = 1'b0;
    sb.push_back(32'h5);
    check(32'(ready_o), 32'd0, "bp_accept_after_idle");
    wait_result(0, 32, "bp_next");
    consume(0, "bp_next");

    // Kill 10 cycles after accept: no result ever appears.
    issue(0, CLMUL, 32'hDEADBEEF, 32'h0F0F0F0F);
    void'(sb.pop_back());
    repeat (9) @(posedge clk);
    #1 kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check(32'(ready_o), 32'd1, "kill_ready");
    check(32'(valid_o), 32'd0, "kill_valid");
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid_o === 1'b1) seen++;
    end
    check(32'(seen), 32'd0, "kill_no_result");

    // Kill together with a request in IDLE starts nothing.
    @(negedge clk);
    valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    check(32'(ready_o), 32'd1, "kill_blocks_accept");

    // Kill while a result is waiting drops it.
    issue(0, CLMUL, 32'h5, 32'h7);
    wait_result(0, 32, "kill_done");
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check(32'(valid_o), 32'd0, "kill_done_valid");
    check(result_o, 32'd0, "kill_done_result");
    check(32'(ready_o), 32'd1, "kill_done_ready");

    // Asynchronous reset mid-operation, then accept on the first edge.
    issue(0, CLMUL, 32'hCAFEF00D, 32'h11111111);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(32'(ready_o), 32'd1, "rst_mid_ready");
    check(32'(valid_o), 32'd0, "rst_mid_valid");
    check(result_o, 32'd0, "rst_mid_result");
    @(posedge clk); #2 rst_n = 1'b1;
    issue(0, CLMUL, 32'h3, 32'h3);
    wait_result(0, 32, "after_reset");
    consume(0, "after_reset");

    // Four bits per cycle: same results at 8-cycle latency.
    issue(1, CLMUL, 32'hFFFFFFFF, 32'hFFFFFFFF);  wait_result(1, 8, "bpc4_clmul");  consume(1, "bpc4_clmul");
    issue(1, CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_result(1, 8, "bpc4_clmulh"); consume(1, "bpc4_clmulh");
    a = $urandom; b = $urandom;
    issue(1, CLMULR, a, b); wait_result(1, 8, "bpc4_random"); consume(1, "bpc4_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
